// File: rtl/hps_reset_arbiter.sv
// -----------------------------------------------------------------------------
// hps_reset_arbiter
//
// Sequences the HPS reset-request lines (cold, warm, debug). Rising edges on the
// three level request inputs are detected, arbitrated by fixed priority
// (cold > warm > debug) and turned into exactly one fixed-width active-high
// reset pulse at a time. Each pulse is followed by a hold-off window during
// which no new pulse may start. Requests arriving while busy are remembered in
// a pending mask and issued later. A running pulse is never preempted.
//
// Optional status outputs (last_type, issue_count) are compiled in when the
// macro HPS_RST_ARB_STATUS_EN is defined. The default build leaves them out.
//
// Ports:
//   clk          in   1  system clock
//   reset_n      in   1  asynchronous active-low reset
//   req          in   3  level requests [0] cold, [1] warm, [2] debug
//   arm          in   3  per-type enable; 0 ignores edges and drops pending
//   cold_reset   out  1  registered cold reset pulse
//   warm_reset   out  1  registered warm reset pulse
//   debug_reset  out  1  registered debug reset pulse
//   busy         out  1  high while a pulse or its hold-off window is running
//   pending      out  3  captured but not yet issued requests
//   last_type    out  2  (HPS_RST_ARB_STATUS_EN) 0 none, 1 cold, 2 warm, 3 debug
//   issue_count  out  8  (HPS_RST_ARB_STATUS_EN) saturating count of pulses
//   fsm_state    out  2  FSM state: 0 IDLE, 1 ASSERT, 2 HOLDOFF
//
// Handshake: there is none; req is a level input sampled every clock and only
// its rising edges matter. Outputs are plain levels, no acknowledge exists.
// -----------------------------------------------------------------------------
module hps_reset_arbiter #(
    parameter int COLD_PULSE  = 6,
    parameter int WARM_PULSE  = 2,
    parameter int DEBUG_PULSE = 32,
    parameter int HOLDOFF     = 1000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    input  logic [2:0] arm,
    output logic       cold_reset,
    output logic       warm_reset,
    output logic       debug_reset,
    output logic       busy,
    output logic [2:0] pending,
`ifdef HPS_RST_ARB_STATUS_EN
    output logic [1:0] last_type,
    output logic [7:0] issue_count,
`endif
    output logic [1:0] fsm_state
);

    // -------------------------------------------------------------------------
    // Parameter legality, checked at elaboration
    // -------------------------------------------------------------------------
    localparam longint CNT_MAX = (longint'(1) << CNT_WIDTH) - 1;

    if (CNT_WIDTH < 1 || CNT_WIDTH > 31) begin : g_bad_cnt_width
        $error("hps_reset_arbiter: CNT_WIDTH must be in 1..31");
    end
    if (COLD_PULSE < 1 || longint'(COLD_PULSE) > CNT_MAX) begin : g_bad_cold
        $error("hps_reset_arbiter: COLD_PULSE must be in 1..2^CNT_WIDTH-1");
    end
    if (WARM_PULSE < 1 || longint'(WARM_PULSE) > CNT_MAX) begin : g_bad_warm
        $error("hps_reset_arbiter: WARM_PULSE must be in 1..2^CNT_WIDTH-1");
    end
    if (DEBUG_PULSE < 1 || longint'(DEBUG_PULSE) > CNT_MAX) begin : g_bad_debug
        $error("hps_reset_arbiter: DEBUG_PULSE must be in 1..2^CNT_WIDTH-1");
    end
    if (HOLDOFF < 0 || longint'(HOLDOFF) > CNT_MAX) begin : g_bad_holdoff
        $error("hps_reset_arbiter: HOLDOFF must be in 0..2^CNT_WIDTH-1");
    end

    // Counter load values. The counter counts down to zero inclusive, so a
    // window of N cycles is loaded with N-1.
    localparam logic [CNT_WIDTH-1:0] COLD_LOAD  = CNT_WIDTH'(COLD_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] WARM_LOAD  = CNT_WIDTH'(WARM_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] DEBUG_LOAD = CNT_WIDTH'(DEBUG_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD  =
        (HOLDOFF > 0) ? CNT_WIDTH'(HOLDOFF - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [2:0]           req_d;     // req history for edge detection
    logic [2:0]           pend;
    logic [2:0]           pend_nxt;
    logic [2:0]           sel;       // one-hot type of the pulse being driven
    logic [2:0]           sel_nxt;

    // -------------------------------------------------------------------------
    // Edge detection and arbitration
    // -------------------------------------------------------------------------
    logic [2:0] edges;
    logic [2:0] cand;
    logic [2:0] win;
    logic       issue;

    always_comb begin
        edges = req & ~req_d & arm;
        // A pending bit whose arm has just dropped must not win this cycle.
        cand  = edges | (pend & arm);
        win   = 3'b000;
        if (cand[0]) begin
            win = 3'b001;
        end else if (cand[1]) begin
            win = 3'b010;
        end else if (cand[2]) begin
            win = 3'b100;
        end
        issue = (state == ST_IDLE) && (cand != 3'b000);
    end

    // -------------------------------------------------------------------------
    // FSM process 1: state register (plus datapath registers it owns)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            // All ones: a request already high when reset releases is not
            // seen as a new edge.
            req_d <= 3'b111;
            pend  <= 3'b000;
            sel   <= 3'b000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            req_d <= req;
            pend  <= pend_nxt;
            sel   <= sel_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state, counter, pulse-type and pending logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;

        unique case (state)
            ST_IDLE: begin
                if (issue) begin
                    state_nxt = ST_ASSERT;
                    sel_nxt   = win;
                    if (win[0]) begin
                        cnt_nxt = COLD_LOAD;
                    end else if (win[1]) begin
                        cnt_nxt = WARM_LOAD;
                    end else begin
                        cnt_nxt = DEBUG_LOAD;
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt == '0) begin
                    sel_nxt = 3'b000;
                    if (HOLDOFF == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HOLDOFF;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                sel_nxt   = 3'b000;
                cnt_nxt   = '0;
            end
        endcase

        // Capture new edges, merge repeats, drop anything disarmed.
        pend_nxt = (pend | edges) & arm;
        if (issue) begin
            if (win[0]) begin
                // A cold reset supersedes everything, including edges that
                // arrive in the same cycle.
                pend_nxt = 3'b000;
            end else begin
                pend_nxt = pend_nxt & ~win;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs. The reset lines come straight from the sel
    // register, which is only non-zero in ASSERT.
    // -------------------------------------------------------------------------
    always_comb begin
        cold_reset  = sel[0];
        warm_reset  = sel[1];
        debug_reset = sel[2];
        busy        = (state != ST_IDLE);
        pending     = pend;
        fsm_state   = state;
    end

`ifdef HPS_RST_ARB_STATUS_EN
    // -------------------------------------------------------------------------
    // Status: type of the most recent pulse and a saturating pulse count,
    // both updated on the edge that enters ASSERT.
    // -------------------------------------------------------------------------
    logic [1:0] type_code;

    always_comb begin
        type_code = 2'd3;
        if (win[0]) begin
            type_code = 2'd1;
        end else if (win[1]) begin
            type_code = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_type   <= 2'd0;
            issue_count <= 8'd0;
        end else if (issue) begin
            last_type <= type_code;
            if (issue_count != 8'hFF) begin
                issue_count <= issue_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hps_reset_arbiter.md
Name: hps_reset_arbiter

Overview:
Sequences the HPS reset-request inputs (cold, warm, debug) of the SoC.
- Detects rising edges on three level request lines and arbitrates them by fixed priority.
- Issues exactly one fixed-width active-high reset pulse at a time, followed by a hold-off window.
- Sits between the source/probe and button request logic and the HPS f2h reset-request ports; the top level inverts its outputs.

Parameters:
COLD_PULSE, 6, cold_reset pulse width in clk cycles (1..2^CNT_WIDTH-1)
WARM_PULSE, 2, warm_reset pulse width in clk cycles
DEBUG_PULSE, 32, debug_reset pulse width in clk cycles
HOLDOFF, 1000, minimum low cycles after any pulse before the next pulse (0 allowed)
CNT_WIDTH, 16, width of the shared pulse/hold-off down-counter

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
req  in  3  level requests: [0] cold, [1] warm, [2] debug; synchronous to clk
arm  in  3  per-type enable, same bit order; 0 = edges of that type ignored and its pending bit cleared
cold_reset  out  1  registered active-high cold reset pulse
warm_reset  out  1  registered active-high warm reset pulse
debug_reset  out  1  registered active-high debug reset pulse
busy  out  1  high in ASSERT or HOLDOFF
pending  out  3  captured but not yet issued requests, same bit order

Behaviour:
Reset (async, reset_n=0):
- All outputs 0; state=IDLE; counter=0; pending=0.
- req_d history register reset to 3'b111, so a request held high across reset does not fire.
- Reset mid-pulse truncates the pulse immediately. Nothing is resumed after release.

Edge detection:
- edge[i] = req[i] & ~req_d[i] & arm[i]; req_d <= req every cycle.
- Cycle-level latency from edge to pulse is defined under the IDLE transition below.

Pending capture:
- pending[i] is set on edge[i] when that edge is not issued in the same cycle.
- pending[i] is cleared when type i is issued, or when arm[i]=0.
- Repeated edges of an already-pending type merge; no count is kept.

Priority:
- cold > warm > debug among (edge | pending).
- Issuing cold clears all pending bits, including edges arriving in that cycle.
- Issuing warm or debug clears only its own bit.

FSM:
- IDLE: if any (edge | pending), select the winner, assert its output at the next clock edge, load counter=PULSE-1, go ASSERT. The output is therefore high starting the cycle after req is first sampled high (1-cycle latency).
- ASSERT: output held. If counter==0, deassert output, load counter=HOLDOFF-1 and go HOLDOFF; if HOLDOFF==0 go IDLE instead. Otherwise decrement. Pulse width is exactly PULSE cycles.
- HOLDOFF: all outputs 0. If counter==0 go IDLE, else decrement. Hold-off is exactly HOLDOFF cycles. The earliest next pulse starts HOLDOFF+1 cycles after the previous pulse falls (one IDLE cycle).
- Requests during ASSERT/HOLDOFF are captured in pending only; preemption never occurs, including cold arriving during a debug pulse.

Invariants:
- At most one of cold_reset, warm_reset, debug_reset is high in any cycle.
- No output is ever high outside ASSERT.
- Counter never wraps; with legal parameters it is loaded only with values in 0..2^CNT_WIDTH-2.
- Parameter legality (PULSE≥1, values < 2^CNT_WIDTH) is checked by an elaboration-time error.

Optional Feature:
Macro HPS_RST_ARB_STATUS_EN.
- Defined: adds ports last_type (out, 2: 0 none, 1 cold, 2 warm, 3 debug) and issue_count (out, 8).
  - Both update on the clock edge entering ASSERT.
  - issue_count saturates at 255.
  - Both reset to 0.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
1. Release reset with req=3'b001 held, arm=3'b111 → no pulse within 100 cycles; drop req[0] and raise it again → cold_reset high exactly 6 cycles, starting 1 cycle after the rise.
2. Single-cycle req[1] pulse → warm_reset high 2 cycles; busy high 2+1000 cycles; a second req[1] edge during hold-off → pending=3'b010, then warm_reset fires 1001 cycles after the first pulse falls.
3. req[0] and req[2] rise in the same cycle → cold_reset 6 cycles only; pending=0 afterwards; no debug_reset ever follows.
4. req[2] edge, then req[0] edge 5 cycles later → debug_reset completes its full 32 cycles; cold_reset starts 1001 cycles after debug_reset falls.
5. arm=3'b101 with a req[1] edge → no pulse, pending[1]=0. Separately, a req[2] edge captured while busy, then arm[2] dropped to 0 → pending[2] clears, no pulse.
6. reset_n asserted on cycle 3 of a cold pulse → cold_reset drops immediately. After release, no pulse occurs, busy=0, and (with HPS_RST_ARB_STATUS_EN) issue_count=0 and last_type=0.
